// File: rtl/velocity_divider.sv
// Fixed-point velocity divider: ux = pux/p and uy = puy/p through two lockstep restoring dividers
// that share one state machine. Results are truncated toward zero and saturated.
module velocity_divider #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  div_start,
  input  logic [DATA_WIDTH-1:0] p,
  input  logic [DATA_WIDTH-1:0] pux,
  input  logic [DATA_WIDTH-1:0] puy,
  output logic [DATA_WIDTH-1:0] ux,
  output logic [DATA_WIDTH-1:0] uy,
  output logic                  div_valid,
  output logic                  busy,
  output logic                  div_by_zero
);

  localparam int unsigned N    = DATA_WIDTH + FRAC_BITS;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [DATA_WIDTH-1:0] MaxPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDivide, StFix, StDone} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] rem_x_q, rem_y_q, rem_x_d, rem_y_d;
  logic [N-1:0]          dq_x_q, dq_y_q, dq_x_d, dq_y_d;
  logic                  neg_x_q, neg_y_q;
  logic [DATA_WIDTH-1:0] ux_q, uy_q, ux_d, uy_d;
  logic                  valid_q, busy_q, dbz_q, dbz_d;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // One restoring step. The dividend shifts out of dq's MSB while quotient bits enter at the LSB.
  function automatic logic [DATA_WIDTH+N-1:0] div_step(input logic [DATA_WIDTH-1:0] rem,
                                                        input logic [N-1:0]          dq,
                                                        input logic [DATA_WIDTH-1:0] dvs);
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] diff;
    trial = {rem, dq[N-1]};
    diff  = trial[DATA_WIDTH-1:0] - dvs;
    if (trial >= {1'b0, dvs}) return {diff, dq[N-2:0], 1'b1};
    return {trial[DATA_WIDTH-1:0], dq[N-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [N-1:0] q, input logic neg);
    if (!neg) return (|q[N-1:DATA_WIDTH-1]) ? MaxPos : q[DATA_WIDTH-1:0];
    if ((|q[N-1:DATA_WIDTH]) || (q[DATA_WIDTH-1] && (|q[DATA_WIDTH-2:0]))) return MinNeg;
    return ~q[DATA_WIDTH-1:0] + 1'b1;
  endfunction

  always_comb begin
    {rem_x_d, dq_x_d} = div_step(rem_x_q, dq_x_q, dvs_q);
    {rem_y_d, dq_y_d} = div_step(rem_y_q, dq_y_q, dvs_q);
    dbz_d = (dvs_q == '0);
    ux_d  = dbz_d ? '0 : apply_sign(dq_x_q, neg_x_q);
    uy_d  = dbz_d ? '0 : apply_sign(dq_y_q, neg_y_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvs_q   <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
      dq_x_q  <= '0;
      dq_y_q  <= '0;
      neg_x_q <= 1'b0;
      neg_y_q <= 1'b0;
      ux_q    <= '0;
      uy_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (div_start) begin
            dvs_q   <= p;
            dq_x_q  <= {pux, {FRAC_BITS{1'b0}}};
            dq_y_q  <= {puy, {FRAC_BITS{1'b0}}};
            rem_x_q <= '0;
            rem_y_q <= '0;
            neg_x_q <= pux[DATA_WIDTH-1] ^ p[DATA_WIDTH-1];
            neg_y_q <= puy[DATA_WIDTH-1] ^ p[DATA_WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= StDivide;
          end
        end
        StDivide: begin
          cnt_q <= cnt_q + 1'b1;
          // First cycle converts the raw captured operands to magnitudes, keeping the negation
          // off the input path; iterations then run on counts 1..N.
          if (cnt_q == '0) begin
            dvs_q  <= mag(dvs_q);
            dq_x_q <= {mag(dq_x_q[N-1:FRAC_BITS]), {FRAC_BITS{1'b0}}};
            dq_y_q <= {mag(dq_y_q[N-1:FRAC_BITS]), {FRAC_BITS{1'b0}}};
          end else begin
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            dq_x_q  <= dq_x_d;
            dq_y_q  <= dq_y_d;
            if (cnt_q == CntW'(N)) state_q <= StFix;
          end
        end
        StFix: begin
          ux_q    <= ux_d;
          uy_q    <= uy_d;
          dbz_q   <= dbz_d;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ux          = ux_q;
  assign uy          = uy_q;
  assign div_valid   = valid_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule
